red_pitaya_iq_synth_block: RTL and testbench

RED_PITAYA_IQ_SYNTH_BLOCK -- requirements
Module: red_pitaya_iq_synth_block

---
 rtl/red_pitaya_iq_synth_block_pkg.sv | 37 +++
 rtl/red_pitaya_iq_synth_block_if.sv | 13 +
 rtl/red_pitaya_cordic_rot_stage.sv | 42 ++++
 rtl/red_pitaya_iq_synth_block.sv | 116 +++++++++++
 tb/tb_red_pitaya_iq_synth_block.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/red_pitaya_iq_synth_block_pkg.sv
// Shared CORDIC constants: arctangent table, inverse gain and quadrant encoding.
// Also used by the phase-detector CORDIC.
package red_pitaya_iq_synth_block_pkg;

  localparam int unsigned CORDIC_ANGLE_BITS = 16;
  localparam int unsigned CORDIC_INV_K      = 19898;
  localparam int unsigned CORDIC_INV_K_FRAC = 15;

  typedef enum logic [1:0] {
    QUAD_0   = 2'd0,
    QUAD_90  = 2'd1,
    QUAD_180 = 2'd2,
    QUAD_270 = 2'd3
  } quad_e;

  // atan(2^-k) in units of 2^-16 turn, rounded to nearest
  function automatic int unsigned cordic_atan(input int unsigned k);
    case (k)
      0:       return 8192;
      1:       return 4836;
      2:       return 2555;
      3:       return 1297;
      4:       return 651;
      5:       return 326;
      6:       return 163;
      7:       return 81;
      8:       return 41;
      9:       return 20;
      10:      return 10;
      11:      return 5;
      12:      return 3;
      13:      return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/red_pitaya_iq_synth_block_if.sv
// Vector link between CORDIC stages: x/y datapath, residual angle z and valid bit.
interface red_pitaya_iq_synth_block_if #(
  parameter int unsigned WW = 18,
  parameter int unsigned ZW = 16
);
  logic signed [WW-1:0] x;
  logic signed [WW-1:0] y;
  logic signed [ZW-1:0] z;
  logic                 v;

  modport master (output x, y, z, v);
  modport slave  (input  x, y, z, v);
endinterface

// File: rtl/red_pitaya_cordic_rot_stage.sv
// One registered CORDIC micro-rotation: rotate toward z=0 by +/-atan(2^-SHIFT).
module red_pitaya_cordic_rot_stage #(
  parameter int unsigned SHIFT = 0,
  parameter int unsigned ATAN  = 8192,
  parameter int unsigned WW    = 18,
  parameter int unsigned ZW    = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  red_pitaya_iq_synth_block_if.slave   up,
  red_pitaya_iq_synth_block_if.master  dn
);

  localparam logic signed [ZW-1:0] ANGLE = ZW'(ATAN);

  logic signed [WW-1:0] x_sh;
  logic signed [WW-1:0] y_sh;

  assign x_sh = up.x >>> SHIFT;
  assign y_sh = up.y >>> SHIFT;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dn.x <= '0;
      dn.y <= '0;
      dn.z <= '0;
      dn.v <= 1'b0;
    end else begin
      dn.v <= up.v;
      if (up.z[ZW-1]) begin
        dn.x <= up.x + y_sh;
        dn.y <= up.y - x_sh;
        dn.z <= up.z + ANGLE;
      end else begin
        dn.x <= up.x - y_sh;
        dn.y <= up.y + x_sh;
        dn.z <= up.z - ANGLE;
      end
    end
  end

endmodule

// File: rtl/red_pitaya_iq_synth_block.sv
// Phase-accumulator IQ synthesiser: i = amp*cos(phase), q = amp*sin(phase) via a
// pipelined CORDIC with gain compensation, rounding and symmetric saturation.
module red_pitaya_iq_synth_block
  import red_pitaya_iq_synth_block_pkg::*;
#(
  parameter int unsigned OUTBITS      = 14,
  parameter int unsigned ACCWIDTH     = 32,
  parameter int unsigned PHASEWIDTH   = 16,
  parameter int unsigned WORKINGWIDTH = 18,
  parameter int unsigned NSTAGES      = 14
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      sync_i,
  input  logic [ACCWIDTH-1:0]       phase_inc_i,
  input  logic [ACCWIDTH-1:0]       phase_ofs_i,
  input  logic signed [OUTBITS-1:0] amp_i,
  output logic signed [OUTBITS-1:0] i_o,
  output logic signed [OUTBITS-1:0] q_o,
  output logic                      valid_o
);

  localparam int unsigned PW     = WORKINGWIDTH + 16;
  localparam int unsigned RSHIFT = CORDIC_INV_K_FRAC + 2;
  localparam logic [PHASEWIDTH-1:0] HALF_QUAD = PHASEWIDTH'(1) << (PHASEWIDTH - 3);
  localparam logic signed [PW-1:0]  INV_K     = PW'(CORDIC_INV_K);
  localparam logic signed [PW-1:0]  RND_HALF  = PW'(1) << (RSHIFT - 1);
  localparam logic signed [PW-1:0]  OUT_MAX   = PW'((1 << (OUTBITS - 1)) - 1);
  localparam logic signed [PW-1:0]  OUT_MIN   = -OUT_MAX;

  logic [ACCWIDTH-1:0]         acc;
  logic [PHASEWIDTH-1:0]       phase;
  quad_e                       quad;
  logic signed [WORKINGWIDTH-1:0] amp_ext;
  logic signed [WORKINGWIDTH-1:0] x0;
  logic signed [WORKINGWIDTH-1:0] y0;
  logic signed [PW-1:0]        x_gain;
  logic signed [PW-1:0]        y_gain;
  logic                        v_gain;

  red_pitaya_iq_synth_block_if #(.WW(WORKINGWIDTH), .ZW(PHASEWIDTH)) rot_if [0:NSTAGES] ();

  // Accumulator; sync clears it after the current sample has been taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc <= '0;
    end else if (en_i) begin
      acc <= sync_i ? '0 : acc + phase_inc_i;
    end
  end

  // Pre-rotation: round phase to nearest quadrant, start vector rotated by n*90 deg
  always_comb begin
    phase   = PHASEWIDTH'((acc + phase_ofs_i) >> (ACCWIDTH - PHASEWIDTH));
    quad    = quad_e'(2'((phase + HALF_QUAD) >> (PHASEWIDTH - 2)));
    amp_ext = {{2{amp_i[OUTBITS-1]}}, amp_i, 2'b00};
    x0      = '0;
    y0      = '0;
    case (quad)
      QUAD_0:   x0 = amp_ext;
      QUAD_90:  y0 = amp_ext;
      QUAD_180: x0 = -amp_ext;
      QUAD_270: y0 = -amp_ext;
    endcase
  end

  assign rot_if[0].x = x0;
  assign rot_if[0].y = y0;
  assign rot_if[0].z = phase - {2'(quad), {(PHASEWIDTH-2){1'b0}}};
  assign rot_if[0].v = en_i;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_rot
    red_pitaya_cordic_rot_stage #(
      .SHIFT (k),
      .ATAN  (cordic_atan(k)),
      .WW    (WORKINGWIDTH),
      .ZW    (PHASEWIDTH)
    ) u_rot (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .up    (rot_if[k]),
      .dn    (rot_if[k+1])
    );
  end

  function automatic logic signed [OUTBITS-1:0] round_sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] r;
    r = (v + RND_HALF) >>> RSHIFT;
    if (r > OUT_MAX)      r = OUT_MAX;
    else if (r < OUT_MIN) r = OUT_MIN;
    return OUTBITS'(r);
  endfunction

  // Gain compensation, then round/saturate into the held output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_gain  <= '0;
      y_gain  <= '0;
      v_gain  <= 1'b0;
      i_o     <= '0;
      q_o     <= '0;
      valid_o <= 1'b0;
    end else begin
      x_gain  <= PW'(rot_if[NSTAGES].x) * INV_K;
      y_gain  <= PW'(rot_if[NSTAGES].y) * INV_K;
      v_gain  <= rot_if[NSTAGES].v;
      valid_o <= v_gain;
      if (v_gain) begin
        i_o <= round_sat(x_gain);
        q_o <= round_sat(y_gain);
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_iq_synth_block.sv
// Scoreboard bench for the IQ synthesiser: directed samples push expected (i,q,edge),
// a negedge monitor pops and compares on every valid_o.
module tb_red_pitaya_iq_synth_block;

  localparam int LAT = 16;
  localparam int TOL = 4;

  typedef struct {
    int edge_at;
    int ei;
    int eq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sync;
  logic [31:0] inc;
  logic [31:0] ofs;
  logic signed [13:0] amp;

  int   edge_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   cos_tab[16];

  red_pitaya_iq_synth_block_if #(.WW(14), .ZW(1)) out_if ();
  assign out_if.z = 1'sb0;

  red_pitaya_iq_synth_block dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .sync_i      (sync),
    .phase_inc_i (inc),
    .phase_ofs_i (ofs),
    .amp_i       (amp),
    .i_o         (out_if.x),
    .q_o         (out_if.y),
    .valid_o     (out_if.v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void check(input string name, input bit ok, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [31:0] p_inc, input logic [31:0] p_ofs,
                      input logic signed [13:0] a, input int ei, input int eq);
    en   = 1'b1;
    sync = s;
    inc  = p_inc;
    ofs  = p_ofs;
    amp  = a;
    exp_q.push_back('{edge_at: edge_n + LAT, ei: ei, eq: eq});
    tick();
    en   = 1'b0;
    sync = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("drain_timeout", exp_q.size() == 0, exp_q.size(), 0);
    repeat (2) tick();
  endtask

  // Monitor: every valid_o must match the oldest expectation, on time
  always @(negedge clk) begin
    exp_t e;
    int   ai, aq;
    if (!rst && exp_q.size() > 0 && exp_q[0].edge_at < edge_n) begin
      check("missing_valid", 1'b0, edge_n, exp_q[0].edge_at);
      void'(exp_q.pop_front());
    end
    if (out_if.v) begin
      ai = int'(out_if.x);
      aq = int'(out_if.y);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1'b0, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency", edge_n == e.edge_at, edge_n, e.edge_at);
        check("i_o", iabs(ai - e.ei) <= TOL, ai, e.ei);
        check("q_o", iabs(aq - e.eq) <= TOL, aq, e.eq);
        check("sat_range", iabs(ai) <= 8191 && iabs(aq) <= 8191, ai, aq);
      end
    end
  end

  initial begin
    cos_tab[0]  = 8191;  cos_tab[1]  = 7567;  cos_tab[2]  = 5792;  cos_tab[3]  = 3135;
    cos_tab[4]  = 0;     cos_tab[5]  = -3135; cos_tab[6]  = -5792; cos_tab[7]  = -7567;
    cos_tab[8]  = -8191; cos_tab[9]  = -7567; cos_tab[10] = -5792; cos_tab[11] = -3135;
    cos_tab[12] = 0;     cos_tab[13] = 3135;  cos_tab[14] = 5792;  cos_tab[15] = 7567;

    rst = 1'b1; en = 1'b0; sync = 1'b0; inc = '0; ofs = '0; amp = '0;
    repeat (3) tick();
    check("reset_valid", out_if.v == 1'b0, int'(out_if.v), 0);
    check("reset_i", out_if.x == 14'sd0, int'(out_if.x), 0);
    check("reset_q", out_if.y == 14'sd0, int'(out_if.y), 0);
    rst = 1'b0;
    tick();

    // Single sample at phase 0
    send(1'b0, 32'd0, 32'd0, 14'sd8191, 8191, 0);
    drain();

    // Quadrant offsets 90/180/270 deg
    send(1'b0, 32'd0, 32'h4000_0000, 14'sd8191, 0, 8191);
    send(1'b0, 32'd0, 32'h8000_0000, 14'sd8191, -8191, 0);
    send(1'b0, 32'd0, 32'hC000_0000, 14'sd8191, 0, -8191);
    drain();

    // Continuous 22.5 deg steps, sync mid-stream, then sync again to park acc at 0
    for (int k = 0; k < 20; k++)
      send(1'b0, 32'h1000_0000, 32'd0, 14'sd8191, cos_tab[k % 16], cos_tab[(k + 12) % 16]);
    send(1'b1, 32'h1000_0000, 32'd0, 14'sd8191, cos_tab[4], cos_tab[0]);
    for (int j = 0; j < 3; j++)
      send(1'b0, 32'h1000_0000, 32'd0, 14'sd8191, cos_tab[j], cos_tab[(j + 12) % 16]);
    send(1'b1, 32'h1000_0000, 32'd0, 14'sd8191, cos_tab[3], cos_tab[15]);
    drain();

    // Negative full-scale amplitude, saturation and zero amplitude
    send(1'b0, 32'd0, 32'h2000_0000, -14'sd8192, -5793, -5793);
    send(1'b0, 32'd0, 32'd0, -14'sd8192, -8191, 0);
    send(1'b0, 32'd0, 32'h2000_0000, 14'sd8191, 5792, 5792);
    send(1'b0, 32'd0, 32'h6000_0000, 14'sd0, 0, 0);
    drain();

    // Reset with 5 samples in flight: all discarded
    for (int k = 0; k < 5; k++)
      send(1'b0, 32'd0, 32'd0, 14'sd8191, 8191, 0);
    repeat (2) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      check("post_reset_valid", out_if.v == 1'b0, int'(out_if.v), 0);
      tick();
    end
    check("post_reset_i", out_if.x == 14'sd0, int'(out_if.x), 0);
    check("post_reset_q", out_if.y == 14'sd0, int'(out_if.y), 0);
    send(1'b0, 32'd0, 32'h4000_0000, 14'sd4000, 0, 4000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
